mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ACCESS_CYCLES, default 2, number of cycles the SRAM strobe is held per access; legal range 1..4.
REQ-002 Clk  in  1  system clock; all state changes on the rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 Req0  in  1  port 0 (CPU) access request; held high until Ack0.
REQ-005 We0  in  1  port 0 write enable: 1 = write, 0 = read.
REQ-006 Addr0  in  20  port 0 word address.
REQ-007 Wdata0  in  16  port 0 write data.
REQ-008 Ack0  out  1  port 0 completion pulse, one cycle wide.
REQ-009 Rdata0  out  16  port 0 read data; valid while Ack0=1.
REQ-010 Req1, We1, Addr1, Wdata1, Ack1, Rdata1 SHALL mirror REQ-004..REQ-009 for port 1 (debug/DMA).
REQ-011 Mem_Addr  out  20  SRAM address.
REQ-012 Mem_Dout  out  16  SRAM write data.
REQ-013 Mem_Din  in  16  SRAM read data.
REQ-014 Mem_Drive  out  1  top-level tristate enable for the SRAM data bus.
REQ-015 Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low.
REQ-016 Busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS and RECOVER, plus a 2-bit cycle counter Cnt.
REQ-018 IDLE: with any Req high, grant per REQ-022, latch the granted port's Addr, We and Wdata, set Cnt=0 and go to ACCESS; otherwise remain in IDLE.
REQ-019 ACCESS: Cnt increments each cycle; when Cnt=ACCESS_CYCLES-1, go to RECOVER, and on a read also register Mem_Din into that port's Rdata on the same edge.
REQ-020 RECOVER: the granted port's Ack=1 for exactly this one cycle; next state is always IDLE.
REQ-021 Req is sampled only in IDLE. The requester drops Req at the edge ending its Ack cycle; Req still high in IDLE is treated as a new access.
REQ-022 Arbitration is round-robin with a Last register holding the most recently granted port. If both ports request, the port not equal to Last wins. A lone requester always wins. Last updates on grant.
REQ-023 Latency: Req high in IDLE at cycle N gives ACCESS in cycles N+1..N+ACCESS_CYCLES and Ack in cycle N+ACCESS_CYCLES+1. Single-port throughput is one access per ACCESS_CYCLES+2 cycles.
REQ-024 In ACCESS: Mem_CE=Mem_UB=Mem_LB=0 and Mem_Addr = latched address.
REQ-025 In ACCESS on a read: Mem_OE=0. In ACCESS on a write: Mem_WE=0, Mem_Drive=1, Mem_Dout = latched data.
REQ-026 In IDLE and RECOVER: all strobes=1 and Mem_Drive=0. RECOVER provides the bus turnaround between accesses.
REQ-027 Changes on Addr, We or Wdata after grant SHALL NOT affect the access in progress.
REQ-028 Rdata0 and Rdata1 are registers that hold their value until the next read on the same port.
REQ-029 Ack0 and Ack1 are never high in the same cycle, and Mem_OE and Mem_WE are never low in the same cycle.

Reset
REQ-030 Reset=0 SHALL immediately force: state=IDLE, Cnt=0, Last=1, Ack0=Ack1=0, Rdata0=Rdata1=0x0000, Mem_Addr=0, Mem_Dout=0, Mem_Drive=0, Busy=0, all strobes=1.
REQ-031 Reset asserted during ACCESS or RECOVER aborts the access with no Ack. Normal operation resumes from IDLE on the first edge after Reset returns to 1.

Verification
REQ-032 Reset=0 mid-run -> all strobes=1, Mem_Drive=0, Ack0=Ack1=0 and Busy=0 in the same cycle, without waiting for a Clk edge.
REQ-033 Port 0 read of 0x00010 with Mem_Din=0xBEEF -> Mem_OE=0 for 2 cycles with Mem_Addr=0x00010, then Ack0=1 with Rdata0=0xBEEF, 3 cycles after Req0.
REQ-034 Port 1 write of 0x1234 to 0x00020 -> Mem_WE=0 and Mem_Drive=1 for 2 cycles with Mem_Dout=0x1234, then a single-cycle Ack1; Mem_OE stays 1 throughout.
REQ-035 Req0 and Req1 held high continuously after reset -> grants alternate 0,1,0,1 with one Ack every 4 cycles and no overlap.
REQ-036 Addr0 changed from 0x00010 to 0x00FFF during ACCESS -> Mem_Addr stays 0x00010 until RECOVER.
REQ-037 ACCESS_CYCLES=1 and ACCESS_CYCLES=4 with a single port-0 read -> Ack0 arrives 2 cycles and 5 cycles after Req0 respectively.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for an asynchronous SRAM: each access holds the
// strobes for ACCESS_CYCLES cycles, then spends one RECOVER cycle on Ack and bus turnaround.
module mem_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        We0,
  input  logic [19:0] Addr0,
  input  logic [15:0] Wdata0,
  output logic        Ack0,
  output logic [15:0] Rdata0,
  input  logic        Req1,
  input  logic        We1,
  input  logic [19:0] Addr1,
  input  logic [15:0] Wdata1,
  output logic        Ack1,
  output logic [15:0] Rdata1,
  output logic [19:0] Mem_Addr,
  output logic [15:0] Mem_Dout,
  input  logic [15:0] Mem_Din,
  output logic        Mem_Drive,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        wr_q, wr_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        ce_q, ce_d;
  logic        oe_q, oe_d;
  logic        we_n_q, we_n_d;
  logic        drive_q, drive_d;
  logic        busy_q, busy_d;
  logic        pick_s;
  logic        in_access_s;

  // Next-state, request latching and next values of the registered SRAM/port outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    pick_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          // Contention goes to the port that was not served last.
          if (Req0 && Req1) begin
            pick_s = ~last_q;
          end else begin
            pick_s = Req1;
          end
          gnt_d   = pick_s;
          last_d  = pick_s;
          wr_d    = pick_s ? We1 : We0;
          addr_d  = pick_s ? Addr1 : Addr0;
          wdata_d = pick_s ? Wdata1 : Wdata0;
          cnt_d   = 2'd0;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = RECOVER;
          if (!wr_q) begin
            if (gnt_q) begin
              rdata1_d = Mem_Din;
            end else begin
              rdata0_d = Mem_Din;
            end
          end else begin
            rdata0_d = rdata0_q;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    in_access_s = (state_d == ACCESS);
    ce_d        = ~in_access_s;
    oe_d        = ~(in_access_s && !wr_d);
    we_n_d      = ~(in_access_s && wr_d);
    drive_d     = in_access_s && wr_d;
    ack0_d      = (state_d == RECOVER) && !gnt_d;
    ack1_d      = (state_d == RECOVER) && gnt_d;
    busy_d      = (state_d != IDLE);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 20'h00000;
      wdata_q  <= 16'h0000;
      rdata0_q <= 16'h0000;
      rdata1_q <= 16'h0000;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      ce_q     <= 1'b1;
      oe_q     <= 1'b1;
      we_n_q   <= 1'b1;
      drive_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      we_n_q   <= we_n_d;
      drive_q  <= drive_d;
      busy_q   <= busy_d;
    end
  end

  assign Ack0      = ack0_q;
  assign Ack1      = ack1_q;
  assign Rdata0    = rdata0_q;
  assign Rdata1    = rdata1_q;
  assign Mem_Addr  = addr_q;
  assign Mem_Dout  = wdata_q;
  assign Mem_Drive = drive_q;
  assign Mem_CE    = ce_q;
  assign Mem_UB    = ce_q;
  assign Mem_LB    = ce_q;
  assign Mem_OE    = oe_q;
  assign Mem_WE    = we_n_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random two-port traffic against a transaction-level arbiter/SRAM model with a
// scoreboard queue; plus directed latency checks for ACCESS_CYCLES of 1 and 4.
module tb_mem_arbiter;
  localparam int AC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req, we;
  logic [19:0] addr [2];
  logic [15:0] wdata [2];
  logic        ack0, ack1, drive, ce, ub, lb, oe, wen, busy;
  logic [15:0] rdata0, rdata1, mem_dout, mem_din;
  logic [19:0] mem_addr;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM stand-in: read data is a fixed function of the address (0x00010 -> 0xBEEF).
  function automatic logic [15:0] hash(input logic [19:0] a);
    return a[15:0] ^ {a[19:16], a[19:16], a[19:16], a[19:16]} ^ 16'hBEFF;
  endfunction

  assign mem_din = oe ? (16'h0BAD ^ mem_addr[15:0]) : hash(mem_addr);

  mem_arbiter #(.ACCESS_CYCLES(AC)) u_dut (
    .Clk(clk), .Reset(rst_n),
    .Req0(req[0]), .We0(we[0]), .Addr0(addr[0]), .Wdata0(wdata[0]), .Ack0(ack0), .Rdata0(rdata0),
    .Req1(req[1]), .We1(we[1]), .Addr1(addr[1]), .Wdata1(wdata[1]), .Ack1(ack1), .Rdata1(rdata1),
    .Mem_Addr(mem_addr), .Mem_Dout(mem_dout), .Mem_Din(mem_din), .Mem_Drive(drive),
    .Mem_CE(ce), .Mem_UB(ub), .Mem_LB(lb), .Mem_OE(oe), .Mem_WE(wen), .Busy(busy)
  );

  // Extra instances: index 0 has ACCESS_CYCLES=1, index 1 has ACCESS_CYCLES=4.
  logic [1:0]  x_req, x_ack0, x_ack1, x_drive, x_ce, x_ub, x_lb, x_oe, x_we, x_busy;
  logic [19:0] x_addr;
  logic [15:0] x_rd0 [2], x_rd1 [2], x_dout [2], x_din [2];
  logic [19:0] x_maddr [2];
  assign x_din[0] = hash(x_maddr[0]);
  assign x_din[1] = hash(x_maddr[1]);

  mem_arbiter #(.ACCESS_CYCLES(1)) u_dut_ac1 (
    .Clk(clk), .Reset(rst_n),
    .Req0(x_req[0]), .We0(1'b0), .Addr0(x_addr), .Wdata0(16'h0000), .Ack0(x_ack0[0]), .Rdata0(x_rd0[0]),
    .Req1(1'b0), .We1(1'b0), .Addr1(20'h00000), .Wdata1(16'h0000), .Ack1(x_ack1[0]), .Rdata1(x_rd1[0]),
    .Mem_Addr(x_maddr[0]), .Mem_Dout(x_dout[0]), .Mem_Din(x_din[0]), .Mem_Drive(x_drive[0]),
    .Mem_CE(x_ce[0]), .Mem_UB(x_ub[0]), .Mem_LB(x_lb[0]), .Mem_OE(x_oe[0]), .Mem_WE(x_we[0]), .Busy(x_busy[0])
  );

  mem_arbiter #(.ACCESS_CYCLES(4)) u_dut_ac4 (
    .Clk(clk), .Reset(rst_n),
    .Req0(x_req[1]), .We0(1'b0), .Addr0(x_addr), .Wdata0(16'h0000), .Ack0(x_ack0[1]), .Rdata0(x_rd0[1]),
    .Req1(1'b0), .We1(1'b0), .Addr1(20'h00000), .Wdata1(16'h0000), .Ack1(x_ack1[1]), .Rdata1(x_rd1[1]),
    .Mem_Addr(x_maddr[1]), .Mem_Dout(x_dout[1]), .Mem_Din(x_din[1]), .Mem_Drive(x_drive[1]),
    .Mem_CE(x_ce[1]), .Mem_UB(x_ub[1]), .Mem_LB(x_lb[1]), .Mem_OE(x_oe[1]), .Mem_WE(x_we[1]), .Busy(x_busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard entry: one granted access, with the cycle in which it was granted.
  typedef struct {
    logic        port;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    int          g;
  } txn_t;

  txn_t        sb[$];
  txn_t        mt;
  txn_t        cur;
  int          free_at = 0;
  logic        last_m = 1'b1;
  logic [15:0] rd_m [2];

  // Reference model: round-robin grant from the requests seen in a free cycle.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      free_at = cyc + 1;
      last_m  = 1'b1;
    end else if (cyc >= free_at && req != 2'b00) begin
      mt.port  = (req == 2'b11) ? ~last_m : req[1];
      last_m   = mt.port;
      mt.we    = we[mt.port];
      mt.addr  = addr[mt.port];
      mt.wdata = wdata[mt.port];
      mt.g     = cyc;
      sb.push_back(mt);
      free_at  = cyc + AC + 2;
    end
  end

  // Monitor: compare every cycle against the phase of the oldest outstanding access.
  initial forever begin
    logic acc, rec;
    logic [8:0] exp_ctrl;
    @(negedge clk);
    if (!rst_n) begin
      rd_m[0] = 16'h0000;
      rd_m[1] = 16'h0000;
      chk("reset_ctrl", 32'({ce, ub, lb, oe, wen, drive, busy, ack0, ack1}), 32'(9'b111110000));
      chk("reset_addr_dout", 32'({mem_addr, mem_dout}), 32'h0);
      chk("reset_rdata", {rdata1, rdata0}, 32'h0);
    end else begin
      acc = 1'b0;
      rec = 1'b0;
      if (sb.size() != 0) begin
        cur = sb[0];
        acc = (cyc >= cur.g + 1) && (cyc <= cur.g + AC);
        rec = (cyc == cur.g + AC + 1);
      end
      exp_ctrl = {~acc, ~acc, ~acc, ~(acc && !cur.we), ~(acc && cur.we), acc && cur.we,
                  acc || rec, rec && !cur.port, rec && cur.port};
      chk("ctrl{ce,ub,lb,oe,we,drive,busy,ack0,ack1}",
          32'({ce, ub, lb, oe, wen, drive, busy, ack0, ack1}), 32'(exp_ctrl));
      if (acc) begin
        chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
        if (cur.we) chk("mem_dout", 32'(mem_dout), 32'(cur.wdata));
      end
      if (rec) begin
        if (!cur.we) rd_m[cur.port] = hash(cur.addr);
        void'(sb.pop_front());
      end
      chk("rdata0", 32'(rdata0), 32'(rd_m[0]));
      chk("rdata1", 32'(rdata1), 32'(rd_m[1]));
    end
  end

  // Random requesters: hold Req until Ack, drop it at the edge ending the Ack cycle.
  task automatic run_phase(input int ncyc, input int p_req, input int p_we, input bit churn);
    logic [1:0] a;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      a = {ack1, ack0};
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (req[p] && a[p]) req[p] = 1'b0;
        if (req[p] && churn) begin
          addr[p]  = 20'($urandom);
          wdata[p] = 16'($urandom);
          we[p]    = 1'($urandom_range(1, 0));
        end
        if (!req[p] && int'($urandom_range(99, 0)) < p_req) begin
          req[p]   = 1'b1;
          we[p]    = (int'($urandom_range(99, 0)) < p_we);
          addr[p]  = 20'($urandom);
          wdata[p] = 16'($urandom);
        end
      end
    end
  endtask

  // One access from an idle arbiter; optionally scrambles the port inputs mid-access.
  task automatic single(input bit p, input bit w, input logic [19:0] a, input logic [15:0] d,
                        input bit change);
    int t0;
    bit got;
    @(posedge clk);
    #1;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    t0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((p ? ack1 : ack0) == 1'b1) begin
        got = 1'b1;
        chk("ack_latency", 32'(cyc - t0), 32'(AC + 1));
      end else if (change && i == 1) begin
        addr[p]  = 20'h00FFF;
        wdata[p] = ~d;
        we[p]    = ~w;
      end
    end
    if (!got) chk("ack_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    req[p] = 1'b0;
  endtask

  task automatic x_latency;
    int t0;
    bit [1:0] got;
    int oe_cnt [2];
    oe_cnt[0] = 0;
    oe_cnt[1] = 0;
    got = 2'b00;
    @(posedge clk);
    #1;
    x_req  = 2'b11;
    x_addr = 20'h00010;
    t0 = cyc;
    for (int i = 0; i < 20 && got != 2'b11; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!got[k]) begin
          if (!x_oe[k]) oe_cnt[k]++;
          if (x_ack0[k]) begin
            got[k]   = 1'b1;
            x_req[k] = 1'b0;
            chk("x_ack_latency", 32'(cyc - t0), (k == 0) ? 32'd2 : 32'd5);
            chk("x_oe_cycles", 32'(oe_cnt[k]), (k == 0) ? 32'd1 : 32'd4);
            chk("x_rdata0", 32'(x_rd0[k]), 32'hBEEF);
            chk("x_recover_outputs",
                32'({x_ce[k], x_ub[k], x_lb[k], x_oe[k], x_we[k], x_drive[k], x_busy[k], x_ack1[k]}),
                32'(8'b11111010));
            chk("x_dout_rdata1", {x_dout[k], x_rd1[k]}, 32'h0);
          end
        end
      end
    end
    if (got != 2'b11) chk("x_ack_timeout", 32'(got), 32'h3);
    x_req = 2'b00;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    req = 2'b00; we = 2'b00;
    addr[0] = 20'h0; addr[1] = 20'h0; wdata[0] = 16'h0; wdata[1] = 16'h0;
    x_req = 2'b00; x_addr = 20'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    single(1'b0, 1'b0, 20'h00010, 16'h0000, 1'b1);
    single(1'b1, 1'b1, 20'h00020, 16'h1234, 1'b0);
    run_phase(24, 100, 50, 1'b0);
    run_phase(12, 0, 0, 1'b0);
    run_phase(600, 40, 50, 1'b1);

    // Asynchronous reset in the middle of a cycle while an access is in flight.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else req[0] = 1'b1;
    end
    chk("busy_before_reset", 32'(seen), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 32'({ce, ub, lb, oe, wen, drive, busy, ack0, ack1}), 32'(9'b111110000));
    req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_phase(400, 60, 50, 1'b1);
    run_phase(12, 0, 0, 1'b0);
    x_latency();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
